split_bus_arbiter: RTL and testbench
====================================

# split_bus_arbiter

Central arbiter for the shared system bus. It grants the bus to one of `NUM_MASTERS` requesting masters using round-robin order. When a slave signals split, it suspends the owning master and releases the bus to other masters. When the split slave later raises its arbiter request, it re-grants the bus to the suspended master. It sits between the master request lines and the bus multiplexer/decoder, and drives the mux select and the split slave's `arbiter_grant`.

## Interface
- `NUM_MASTERS`, default 2: number of masters; legal range 2..8.
- `TIMEOUT`, default 32: maximum cycles a grant may stay outstanding without `bus_ready`.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `m_req`  in  `NUM_MASTERS`  per-master bus request; held high until the master's transaction completes, including while it is suspended.
- `bus_ready`  in  1  muxed slave ready; completes the current transaction.
- `bus_split`  in  1  muxed slave split; suspends the current transaction.
- `s_arb_req`  in  1  split slave requests the bus back to finish a suspended transaction.
- `m_grant`  out  `NUM_MASTERS`  one-hot grant; all zero when the bus is idle.
- `bus_owner`  out  `$clog2(NUM_MASTERS)`  index of the granted master; drives the bus mux select.
- `owner_valid`  out  1  equals `|m_grant`.
- `s_grant`  out  1  one-cycle pulse to the split slave (its `arbiter_grant`).
- `timeout_err`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- FSM states: `IDLE`, `OWN`, `RESUME`.
- Internal registers:
  - `split_pending` (1 bit).
  - `split_owner` (index of the suspended master).
  - `rr_last` (last master granted; resets to `NUM_MASTERS-1`, so M0 wins first).
  - `tcnt` (timeout counter, width `$clog2(TIMEOUT+1)`).
- `IDLE`, checked in priority order:
  1. If `split_pending && s_arb_req`: set `m_grant` to one-hot(`split_owner`) and `s_grant`=1, then go to `RESUME`.
  2. Otherwise, if any eligible request exists, grant the first requester searching upward from `rr_last+1` with wrap-around, update `rr_last`, and go to `OWN`.
  - Eligible means `m_req[i]` is high and, while `split_pending`, `i != split_owner`.
- `OWN`:
  - `bus_ready` high: clear the grant and go to `IDLE`.
  - `bus_split` high without `bus_ready`: set `split_pending`=1, `split_owner`=`bus_owner`, clear the grant, go to `IDLE`.
  - `bus_ready` and `bus_split` high together: `bus_ready` wins; no split is recorded.
- `RESUME`:
  - `s_grant` returns to 0 after one cycle.
  - On `bus_ready`: clear `split_pending` and the grant, then go to `IDLE`.
  - `bus_split` is ignored in this state.
- `s_arb_req` is serviced only from `IDLE`; it never preempts a current owner.
- `s_arb_req` with no split pending is ignored.
- Only one split may be outstanding at a time. Address-decode protection of the split slave while a split is pending belongs to the decoder, not this block.
- Timeout:
  - `tcnt` clears on every entry to `OWN` or `RESUME` and increments every cycle spent in those states.
  - When `tcnt` reaches `TIMEOUT-1` without `bus_ready`: pulse `timeout_err`, clear the grant, go to `IDLE`.
  - A timeout in `RESUME` also clears `split_pending`.

## Timing
- All outputs are registered.
- Reset values: `m_grant`=0, `bus_owner`=0, `owner_valid`=0, `s_grant`=0, `timeout_err`=0.
- Reset also sets state=`IDLE`, `split_pending`=0, `rr_last`=`NUM_MASTERS-1`.
- Reset has priority in every state, including mid-`OWN` and mid-`RESUME`.
- Grant latency: request sampled in `IDLE` at edge t; grant visible from cycle t+1.
- Release: `bus_ready` or `bus_split` sampled at edge t clears the grant in cycle t+1.
- Turnaround: there is always at least one `IDLE` cycle with no grant between owners.
- Resume handshake:
  - `s_grant` is high for exactly cycle t+1.
  - The slave asserts ready at t+2; the arbiter releases at t+3.

## Structure
- Package `bus_arb_pkg`:
  - `arb_state_t` enum (`IDLE`/`OWN`/`RESUME`).
  - Default constants for `NUM_MASTERS` and `TIMEOUT`.
- Sub-module `rr_picker`: combinational round-robin search.
  - Inputs: request vector, mask, `rr_last`.
  - Outputs: one-hot grant, index, found flag.

## Test plan
- Single master: M0 asserts `m_req`; slave `bus_ready` 3 cycles after grant -> `m_grant`=01 one cycle after the request; `bus_owner`=0; grant cleared the cycle after ready.
- Fairness: M0 and M1 request together after reset, each completing with `bus_ready` -> grants in order M0, M1, M0, each separated by one idle cycle.
- Split and resume:
  - M0 granted, `bus_split` pulses -> grant drops and `split_pending`=1.
  - M1 is granted next, and M0 stays masked.
  - `s_arb_req` asserted during M1 ownership -> held off until M1's `bus_ready`.
  - Then `m_grant`=01 with a one-cycle `s_grant`, even if M1 still requests.
  - Ready clears the pending split.
- `bus_ready` and `bus_split` high in the same cycle -> normal completion, no pending split.
- Timeout: grant M1 and never assert ready -> after 32 cycles in `OWN`, `timeout_err` pulses once and the grant clears.
- Reset mid-`RESUME` -> every output 0 the next cycle; a later `s_arb_req` is ignored.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and default parameters for the split-capable bus arbiter.
package bus_arb_pkg;

  // Arbiter FSM states.
  //   IDLE   : no master owns the bus; pick the next owner or resume a split.
  //   OWN    : a master owns the bus for a normal transaction.
  //   RESUME : the suspended master is re-granted to finish its split transaction.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN    = 2'd1,
    RESUME = 2'd2
  } arb_state_t;

  // Default number of masters sharing the bus (legal range 2..8).
  localparam int DEF_NUM_MASTERS = 2;

  // Default number of cycles a grant may stay outstanding without bus_ready.
  localparam int DEF_TIMEOUT = 32;

endpackage : bus_arb_pkg

// File: rtl/split_bus_arbiter_rr_picker.sv
// Combinational round-robin search: starting just after rr_last_i and
// wrapping around, pick the first requester that the mask allows.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] rr_last_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  logic [N-1:0] elig;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_elig
      assign elig[gi] = req_i[gi] & mask_i[gi];
    end
  endgenerate

  int            pos;
  logic [IW-1:0] sel;

  // Scan offsets from farthest to nearest so the nearest eligible requester
  // after rr_last wins (later assignments override earlier ones).
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found_o = 1'b0;
    pos     = 0;
    sel     = '0;
    for (int k = N; k >= 1; k--) begin
      pos = int'(rr_last_i) + k;
      if (pos >= N) begin
        pos = pos - N;
      end
      sel = IW'(pos);
      if (elig[sel]) begin
        grant_o      = '0;
        grant_o[sel] = 1'b1;
        idx_o        = sel;
        found_o      = 1'b1;
      end
    end
  end

endmodule : rr_picker

// File: rtl/split_bus_arbiter.sv
// Central round-robin bus arbiter with split/resume support.
// A master whose slave answers with split is suspended and masked out of
// arbitration until the split slave asks for the bus back; the suspended
// master is then re-granted ahead of any new requester. All outputs are
// registered; there is always an idle cycle between two owners.
module split_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_MASTERS-1:0]         m_req,
  input  logic                           bus_ready,
  input  logic                           bus_split,
  input  logic                           s_arb_req,
  output logic [NUM_MASTERS-1:0]         m_grant,
  output logic [$clog2(NUM_MASTERS)-1:0] bus_owner,
  output logic                           owner_valid,
  output logic                           s_grant,
  output logic                           timeout_err
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] RR_RESET  = IW'(NUM_MASTERS - 1);

  arb_state_t             state_q, state_d;
  logic                   split_pending_q, split_pending_d;
  logic [IW-1:0]          split_owner_q, split_owner_d;
  logic [IW-1:0]          rr_last_q, rr_last_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic [NUM_MASTERS-1:0] m_grant_q, m_grant_d;
  logic [IW-1:0]          bus_owner_q, bus_owner_d;
  logic                   owner_valid_q, owner_valid_d;
  logic                   s_grant_q, s_grant_d;
  logic                   timeout_err_q, timeout_err_d;

  logic [NUM_MASTERS-1:0] req_mask;
  logic [NUM_MASTERS-1:0] pick_grant;
  logic [IW-1:0]          pick_idx;
  logic                   pick_found;

  // While a split is outstanding, the suspended master may not win ordinary
  // arbitration even though it keeps its request line high.
  always_comb begin
    req_mask = '1;
    if (split_pending_q) begin
      req_mask[split_owner_q] = 1'b0;
    end
  end

  rr_picker #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_rr_picker (
    .req_i     (m_req),
    .mask_i    (req_mask),
    .rr_last_i (rr_last_q),
    .grant_o   (pick_grant),
    .idx_o     (pick_idx),
    .found_o   (pick_found)
  );

  // Next-state logic for the arbiter FSM and its registered outputs.
  always_comb begin
    state_d         = state_q;
    split_pending_d = split_pending_q;
    split_owner_d   = split_owner_q;
    rr_last_d       = rr_last_q;
    tcnt_d          = tcnt_q;
    m_grant_d       = m_grant_q;
    bus_owner_d     = bus_owner_q;
    s_grant_d       = 1'b0;
    timeout_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (split_pending_q && s_arb_req) begin
          // Resuming the suspended master takes precedence over new requests.
          m_grant_d                = '0;
          m_grant_d[split_owner_q] = 1'b1;
          bus_owner_d              = split_owner_q;
          s_grant_d                = 1'b1;
          tcnt_d                   = '0;
          state_d                  = RESUME;
        end else if (pick_found) begin
          m_grant_d   = pick_grant;
          bus_owner_d = pick_idx;
          rr_last_d   = pick_idx;
          tcnt_d      = '0;
          state_d     = OWN;
        end
      end

      OWN: begin
        tcnt_d = tcnt_q + TW'(1);
        if (bus_ready) begin
          // Ready wins over a simultaneous split: the transfer completed.
          m_grant_d = '0;
          state_d   = IDLE;
        end else if (bus_split) begin
          split_pending_d = 1'b1;
          split_owner_d   = bus_owner_q;
          m_grant_d       = '0;
          state_d         = IDLE;
        end else if (tcnt_q == TCNT_LAST) begin
          timeout_err_d = 1'b1;
          m_grant_d     = '0;
          state_d       = IDLE;
        end
      end

      RESUME: begin
        // A second split from the resumed transfer is not supported and is ignored.
        tcnt_d = tcnt_q + TW'(1);
        if (bus_ready) begin
          split_pending_d = 1'b0;
          m_grant_d       = '0;
          state_d         = IDLE;
        end else if (tcnt_q == TCNT_LAST) begin
          // Give up on the suspended transfer entirely so the bus cannot lock up.
          timeout_err_d   = 1'b1;
          split_pending_d = 1'b0;
          m_grant_d       = '0;
          state_d         = IDLE;
        end
      end

      default: begin
        m_grant_d = '0;
        state_d   = IDLE;
      end
    endcase

    owner_valid_d = |m_grant_d;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      split_pending_q <= 1'b0;
      split_owner_q   <= '0;
      rr_last_q       <= RR_RESET;
      tcnt_q          <= '0;
      m_grant_q       <= '0;
      bus_owner_q     <= '0;
      owner_valid_q   <= 1'b0;
      s_grant_q       <= 1'b0;
      timeout_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      split_pending_q <= split_pending_d;
      split_owner_q   <= split_owner_d;
      rr_last_q       <= rr_last_d;
      tcnt_q          <= tcnt_d;
      m_grant_q       <= m_grant_d;
      bus_owner_q     <= bus_owner_d;
      owner_valid_q   <= owner_valid_d;
      s_grant_q       <= s_grant_d;
      timeout_err_q   <= timeout_err_d;
    end
  end

  assign m_grant     = m_grant_q;
  assign bus_owner   = bus_owner_q;
  assign owner_valid = owner_valid_q;
  assign s_grant     = s_grant_q;
  assign timeout_err = timeout_err_q;

endmodule : split_bus_arbiter

// File: tb/tb_split_bus_arbiter.sv
// Testbench for split_bus_arbiter: directed scenarios with literal checks,
// plus a cycle-by-cycle comparison against a transaction-level model.
module tb_split_bus_arbiter;

  localparam int NM = 2;
  localparam int TO = 32;
  localparam int OW = $clog2(NM);

  logic          clk;
  logic          rst_n;
  logic [NM-1:0] m_req;
  logic          bus_ready;
  logic          bus_split;
  logic          s_arb_req;
  logic [NM-1:0] m_grant;
  logic [OW-1:0] bus_owner;
  logic          owner_valid;
  logic          s_grant;
  logic          timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  split_bus_arbiter #(
    .NUM_MASTERS (NM),
    .TIMEOUT     (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m_req       (m_req),
    .bus_ready   (bus_ready),
    .bus_split   (bus_split),
    .s_arb_req   (s_arb_req),
    .m_grant     (m_grant),
    .bus_owner   (bus_owner),
    .owner_valid (owner_valid),
    .s_grant     (s_grant),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The bus is described by who holds it (-1 = nobody), whether that hold is
  // a resumed split transfer, how long it has been held, and which master (if
  // any) is parked on a split.
  int            mdl_owner = -1;
  bit            mdl_resume = 0;
  int            mdl_age = 0;
  bit            mdl_pend = 0;
  int            mdl_pown = 0;
  int            mdl_last = NM - 1;
  logic [NM-1:0] exp_grant = '0;
  int            exp_owner = 0;
  bit            exp_sg = 0;
  bit            exp_to = 0;
  bit            mdl_ok = 0;

  always begin
    @(posedge clk);
    if (!rst_n) begin
      mdl_ok     = 1;
      mdl_owner  = -1;
      mdl_resume = 0;
      mdl_age    = 0;
      mdl_pend   = 0;
      mdl_pown   = 0;
      mdl_last   = NM - 1;
      exp_owner  = 0;
      exp_sg     = 0;
      exp_to     = 0;
    end else begin
      exp_sg = 0;
      exp_to = 0;
      if (mdl_owner < 0) begin
        if (mdl_pend && s_arb_req) begin
          mdl_owner  = mdl_pown;
          mdl_resume = 1;
          mdl_age    = 0;
          exp_sg     = 1;
        end else begin
          for (int k = 1; k <= NM; k++) begin
            int c;
            c = (mdl_last + k) % NM;
            if (mdl_owner < 0 && m_req[c] && !(mdl_pend && c == mdl_pown)) begin
              mdl_owner  = c;
              mdl_last   = c;
              mdl_resume = 0;
              mdl_age    = 0;
            end
          end
        end
        if (mdl_owner >= 0) exp_owner = mdl_owner;
      end else begin
        if (bus_ready) begin
          if (mdl_resume) mdl_pend = 0;
          mdl_owner = -1;
        end else if (!mdl_resume && bus_split) begin
          mdl_pend  = 1;
          mdl_pown  = mdl_owner;
          mdl_owner = -1;
        end else if (mdl_age == TO - 1) begin
          exp_to = 1;
          if (mdl_resume) mdl_pend = 0;
          mdl_owner = -1;
        end else begin
          mdl_age++;
        end
      end
    end
    exp_grant = (mdl_owner >= 0) ? NM'(1 << mdl_owner) : '0;
    #1;
    if (mdl_ok) begin
      check("cyc_m_grant", 32'(m_grant), 32'(exp_grant));
      check("cyc_bus_owner", 32'(bus_owner), 32'(exp_owner));
      check("cyc_owner_valid", 32'(owner_valid), 32'(|exp_grant));
      check("cyc_s_grant", 32'(s_grant), 32'(exp_sg));
      check("cyc_timeout_err", 32'(timeout_err), 32'(exp_to));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    m_req     = '0;
    bus_ready = 1'b0;
    bus_split = 1'b0;
    s_arb_req = 1'b0;

    // Reset state
    tick(2);
    check("rst_m_grant", 32'(m_grant), 32'h0);
    check("rst_owner_valid", 32'(owner_valid), 32'h0);
    check("rst_s_grant", 32'(s_grant), 32'h0);
    check("rst_timeout_err", 32'(timeout_err), 32'h0);
    rst_n = 1'b1;
    tick(1);

    // Single master, ready three cycles after grant
    m_req = 2'b01;
    tick(1);
    check("single_grant", 32'(m_grant), 32'h1);
    check("single_owner", 32'(bus_owner), 32'h0);
    check("single_valid", 32'(owner_valid), 32'h1);
    tick(2);
    bus_ready = 1'b1;
    tick(1);
    bus_ready = 1'b0;
    m_req     = 2'b00;
    check("single_release", 32'(m_grant), 32'h0);
    tick(2);

    // Fairness: M0, idle, M1, idle, M0
    do_reset();
    m_req = 2'b11;
    tick(1);
    check("fair_1st_M0", 32'(m_grant), 32'h1);
    bus_ready = 1'b1;
    tick(1);
    bus_ready = 1'b0;
    check("fair_gap1", 32'(m_grant), 32'h0);
    tick(1);
    check("fair_2nd_M1", 32'(m_grant), 32'h2);
    check("fair_2nd_owner", 32'(bus_owner), 32'h1);
    bus_ready = 1'b1;
    tick(1);
    bus_ready = 1'b0;
    check("fair_gap2", 32'(m_grant), 32'h0);
    tick(1);
    check("fair_3rd_M0", 32'(m_grant), 32'h1);
    bus_ready = 1'b1;
    tick(1);
    bus_ready = 1'b0;
    m_req     = 2'b00;
    tick(2);

    // Split and resume
    do_reset();
    m_req = 2'b11;
    tick(1);
    check("split_M0_grant", 32'(m_grant), 32'h1);
    bus_split = 1'b1;
    tick(1);
    bus_split = 1'b0;
    check("split_drop", 32'(m_grant), 32'h0);
    tick(1);
    check("split_M1_next", 32'(m_grant), 32'h2);
    s_arb_req = 1'b1;
    tick(2);
    check("split_no_preempt", 32'(m_grant), 32'h2);
    check("split_no_sgrant", 32'(s_grant), 32'h0);
    bus_ready = 1'b1;
    tick(1);
    bus_ready = 1'b0;
    check("split_M1_done", 32'(m_grant), 32'h0);
    tick(1);
    check("resume_grant_M0", 32'(m_grant), 32'h1);
    check("resume_s_grant", 32'(s_grant), 32'h1);
    check("resume_owner", 32'(bus_owner), 32'h0);
    s_arb_req = 1'b0;
    tick(1);
    check("resume_sg_pulse", 32'(s_grant), 32'h0);
    check("resume_hold", 32'(m_grant), 32'h1);
    bus_ready = 1'b1;
    tick(1);
    bus_ready = 1'b0;
    check("resume_release", 32'(m_grant), 32'h0);
    tick(1);
    check("pend_cleared_M0", 32'(m_grant), 32'h1);
    bus_ready = 1'b1;
    tick(1);
    bus_ready = 1'b0;
    m_req     = 2'b00;
    tick(2);

    // Ready and split together: plain completion
    do_reset();
    m_req = 2'b01;
    tick(1);
    check("rs_grant", 32'(m_grant), 32'h1);
    bus_ready = 1'b1;
    bus_split = 1'b1;
    tick(1);
    bus_ready = 1'b0;
    bus_split = 1'b0;
    check("rs_release", 32'(m_grant), 32'h0);
    tick(1);
    check("rs_no_pending", 32'(m_grant), 32'h1);
    bus_ready = 1'b1;
    tick(1);
    bus_ready = 1'b0;
    m_req     = 2'b00;
    tick(2);

    // Timeout on M1
    do_reset();
    m_req = 2'b10;
    tick(1);
    check("to_grant_M1", 32'(m_grant), 32'h2);
    tick(31);
    check("to_still_held", 32'(m_grant), 32'h2);
    check("to_not_yet", 32'(timeout_err), 32'h0);
    tick(1);
    check("to_revoked", 32'(m_grant), 32'h0);
    check("to_pulse", 32'(timeout_err), 32'h1);
    m_req = 2'b00;
    tick(1);
    check("to_pulse_once", 32'(timeout_err), 32'h0);
    tick(1);

    // Reset during RESUME
    do_reset();
    m_req = 2'b01;
    tick(1);
    bus_split = 1'b1;
    tick(1);
    bus_split = 1'b0;
    s_arb_req = 1'b1;
    tick(1);
    check("rr_resume_sg", 32'(s_grant), 32'h1);
    s_arb_req = 1'b0;
    tick(1);
    rst_n = 1'b0;
    m_req = 2'b00;
    tick(1);
    check("rr_grant_zero", 32'(m_grant), 32'h0);
    check("rr_owner_zero", 32'(bus_owner), 32'h0);
    check("rr_valid_zero", 32'(owner_valid), 32'h0);
    check("rr_sg_zero", 32'(s_grant), 32'h0);
    rst_n     = 1'b1;
    s_arb_req = 1'b1;
    tick(2);
    check("rr_sarb_ignored", 32'(m_grant), 32'h0);
    check("rr_sarb_no_sg", 32'(s_grant), 32'h0);
    s_arb_req = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_split_bus_arbiter
